// File: rtl/xctcmsg_receive_matcher_if.sv
// Purpose: payload types and the bundled handshake interface for the receive matcher.
// Package types:
//   interface_receive_data_t  - inbound network message (meta + data)
//   receive_queue_data_t      - RECV/AVAIL request (is_avail, meta, meta_mask, passthrough)
//   writeback_arbiter_data_t  - result to the writeback arbiter (value, passthrough)
// Interface signals (slave = matcher side):
//   net_valid_i/net_ready_o/net_data_i   inbound message handshake
//   req_valid_i/req_ready_o/req_data_i   receive-queue request handshake
//   wb_valid_o/wb_ready_i/wb_data_o      writeback result handshake
//   occupancy_o                          number of buffered messages
package xctcmsg_receive_matcher_pkg;
  localparam int unsigned TAG_W  = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned PT_W   = 8;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
  } meta_t;

  typedef struct packed {
    meta_t             meta;
    logic [DATA_W-1:0] data;
  } interface_receive_data_t;

  typedef struct packed {
    logic            is_avail;
    meta_t           meta;
    meta_t           meta_mask;
    logic [PT_W-1:0] passthrough;
  } receive_queue_data_t;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [PT_W-1:0]   passthrough;
  } writeback_arbiter_data_t;
endpackage

interface xctcmsg_receive_matcher_if
  import xctcmsg_receive_matcher_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                    net_valid_i;
  logic                    net_ready_o;
  interface_receive_data_t net_data_i;
  logic                    req_valid_i;
  logic                    req_ready_o;
  receive_queue_data_t     req_data_i;
  logic                    wb_valid_o;
  logic                    wb_ready_i;
  writeback_arbiter_data_t wb_data_o;
  logic [CNT_W-1:0]        occupancy_o;

  modport slave (
    input  net_valid_i, net_data_i, req_valid_i, req_data_i, wb_ready_i,
    output net_ready_o, req_ready_o, wb_valid_o, wb_data_o, occupancy_o
  );

  modport master (
    output net_valid_i, net_data_i, req_valid_i, req_data_i, wb_ready_i,
    input  net_ready_o, req_ready_o, wb_valid_o, wb_data_o, occupancy_o
  );
endinterface

// File: rtl/xctcmsg_receive_matcher.sv
// Purpose: buffers inbound messages in arrival order and serves RECV/AVAIL
// requests by masked tag/address match, producing one registered result per
// accepted request with a latency of one cycle.
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset
//   bus  - xctcmsg_receive_matcher_if.slave (net, req, wb handshakes, occupancy)
module xctcmsg_receive_matcher
  import xctcmsg_receive_matcher_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  xctcmsg_receive_matcher_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  interface_receive_data_t r_entries [DEPTH];
  logic [CNT_W-1:0]        r_count;
  logic                    r_wb_valid;
  writeback_arbiter_data_t r_wb_data;

  receive_queue_data_t     w_req;
  logic [DEPTH-1:0]        w_hit;
  logic                    w_any_hit;
  logic [IDX_W-1:0]        w_sel;
  logic                    w_slot_free;
  logic                    w_net_ready;
  logic                    w_req_ready;
  logic                    w_req_fire;
  logic                    w_remove;
  logic                    w_net_fire;
  logic [CNT_W-1:0]        w_ins_idx;
  interface_receive_data_t w_entries_nxt [DEPTH];

  assign w_req = bus.req_data_i;

  // Per-entry masked compare against pre-cycle contents only (no bypass).
  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_hit[i] = (CNT_W'(i) < r_count) &&
                 (((r_entries[i].meta ^ w_req.meta) & w_req.meta_mask) == '0);
    end
  end

  // Oldest hit wins: scan downward so the lowest index is the last written.
  always_comb begin
    w_any_hit = 1'b0;
    w_sel     = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any_hit = 1'b1;
        w_sel     = IDX_W'(i);
      end
    end
  end

  assign w_slot_free = !r_wb_valid || bus.wb_ready_i;
  assign w_net_ready = (r_count < CNT_W'(DEPTH));
  assign w_req_ready = w_slot_free && (w_req.is_avail || w_any_hit);
  assign w_req_fire  = bus.req_valid_i && w_req_ready;
  assign w_remove    = w_req_fire && !w_req.is_avail;
  assign w_net_fire  = bus.net_valid_i && w_net_ready;
  // Insert lands after the compaction caused by a same-cycle removal.
  assign w_ins_idx   = r_count - CNT_W'(w_remove);

  // Compact above the removed entry, then append the new arrival.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_entries_nxt[i] = r_entries[i];
    end
    if (w_remove) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= w_sel) begin
          w_entries_nxt[i] = r_entries[i + 1];
        end
      end
    end
    if (w_net_fire) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == w_ins_idx) begin
          w_entries_nxt[i] = bus.net_data_i;
        end
      end
    end
  end

  // Entry payloads need no reset; validity is defined by r_count.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      r_entries[i] <= w_entries_nxt[i];
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_net_fire) - CNT_W'(w_remove);
    end
  end

  // Single output slot: load on accept, clear on handshake, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
    end else if (w_req_fire) begin
      r_wb_valid            <= 1'b1;
      r_wb_data.passthrough <= w_req.passthrough;
      r_wb_data.value       <= w_req.is_avail ? DATA_W'(w_any_hit)
                                              : r_entries[w_sel].data;
    end else if (bus.wb_ready_i) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign bus.net_ready_o = w_net_ready;
  assign bus.req_ready_o = w_req_ready;
  assign bus.wb_valid_o  = r_wb_valid;
  assign bus.wb_data_o   = r_wb_data;
  assign bus.occupancy_o = r_count;
endmodule

// File: tb/tb_xctcmsg_receive_matcher.sv
// Purpose: self-checking bench for xctcmsg_receive_matcher: a directed vector
// table, hand-written multi-cycle sequences (stall, full/backpressure, reset),
// and randomized traffic against a queue-based reference model.
module tb_xctcmsg_receive_matcher;
  import xctcmsg_receive_matcher_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xctcmsg_receive_matcher_if #(.DEPTH(DEPTH)) bus ();

  xctcmsg_receive_matcher #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        nv;
    logic [31:0] ntag;
    logic [63:0] ndata;
    logic        rv;
    logic        av;
    logic [31:0] rtag;
    logic [31:0] tmask;
    logic        wr;
    logic        e_nr;
    logic        e_rr;
    logic        e_wbv;
    logic [63:0] e_val;
    int          e_occ;
  } vec_t;

  vec_t vecs [20];

  // Reference model state
  interface_receive_data_t mq [$];
  logic                    m_wbv;
  logic [63:0]             m_val;
  logic [7:0]              m_pt;

  writeback_arbiter_data_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic nv, input logic [31:0] ntag, input logic [63:0] ndata,
                       input logic rv, input logic av, input logic [31:0] rtag,
                       input logic [31:0] tmask, input logic wr);
    bus.net_valid_i                   = nv;
    bus.net_data_i.meta.tag           = ntag;
    bus.net_data_i.meta.addr          = '0;
    bus.net_data_i.data               = ndata;
    bus.req_valid_i                   = rv;
    bus.req_data_i.is_avail           = av;
    bus.req_data_i.meta.tag           = rtag;
    bus.req_data_i.meta.addr          = '0;
    bus.req_data_i.meta_mask.tag      = tmask;
    bus.req_data_i.meta_mask.addr     = '0;
    bus.req_data_i.passthrough        = '0;
    bus.wb_ready_i                    = wr;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One randomized cycle: drive, compare to model before the edge, advance model.
  task automatic rand_cycle();
    int          hit;
    logic        e_nr;
    logic        e_rr;
    logic        slot_free;
    int unsigned msel;
    receive_queue_data_t rq;

    bus.net_valid_i          = 1'($urandom_range(0, 1));
    bus.net_data_i.meta.tag  = 32'($urandom_range(0, 3));
    bus.net_data_i.meta.addr = 32'($urandom_range(0, 1));
    bus.net_data_i.data      = {$urandom, $urandom};
    bus.req_valid_i          = 1'($urandom_range(0, 1));
    rq.is_avail              = ($urandom_range(0, 9) < 3);
    rq.meta.tag              = 32'($urandom_range(0, 3));
    rq.meta.addr             = 32'($urandom_range(0, 1));
    msel                     = $urandom_range(0, 3);
    case (msel)
      0:       rq.meta_mask = '0;
      1:       rq.meta_mask = '{tag: 32'hFFFF_FFFF, addr: 32'h0};
      2:       rq.meta_mask = '{tag: 32'hFFFF_FFFF, addr: 32'hFFFF_FFFF};
      default: rq.meta_mask = '{tag: 32'h1, addr: 32'h0};
    endcase
    rq.passthrough           = 8'($urandom);
    bus.req_data_i           = rq;
    bus.wb_ready_i           = ($urandom_range(0, 9) < 7);

    @(negedge clk);
    hit = -1;
    foreach (mq[i]) begin
      if (hit < 0 && (((mq[i].meta ^ rq.meta) & rq.meta_mask) == '0)) hit = i;
    end
    slot_free = !m_wbv || bus.wb_ready_i;
    e_nr      = (mq.size() < DEPTH);
    e_rr      = slot_free && (rq.is_avail || hit >= 0);

    chk("rnd_net_ready", bus.net_ready_o, e_nr);
    chk("rnd_req_ready", bus.req_ready_o, e_rr);
    chk("rnd_wb_valid", bus.wb_valid_o, m_wbv);
    chk("rnd_occupancy", 64'(bus.occupancy_o), 64'(mq.size()));
    if (m_wbv) begin
      chk("rnd_wb_value", bus.wb_data_o.value, m_val);
      chk("rnd_wb_pt", 64'(bus.wb_data_o.passthrough), 64'(m_pt));
    end

    if (bus.req_valid_i && e_rr) begin
      m_wbv = 1'b1;
      m_pt  = rq.passthrough;
      if (rq.is_avail) begin
        m_val = (hit >= 0) ? 64'd1 : 64'd0;
      end else begin
        m_val = mq[hit].data;
        mq.delete(hit);
      end
    end else if (bus.wb_ready_i) begin
      m_wbv = 1'b0;
    end
    if (bus.net_valid_i && e_nr) mq.push_back(bus.net_data_i);
    tick();
  endtask

  initial begin
    // nv ntag ndata rv av rtag tmask wr | nr rr wbv val occ
    vecs[0]  = '{1'b1, 32'h10, 64'hA,  1'b0, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,  0};
    vecs[1]  = '{1'b1, 32'h10, 64'hB,  1'b0, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,  1};
    vecs[2]  = '{1'b0, 32'h0,  64'h0,  1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,  2};
    vecs[3]  = '{1'b0, 32'h0,  64'h0,  1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 64'hA,  1};
    vecs[4]  = '{1'b0, 32'h0,  64'h0,  1'b0, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 64'hB,  0};
    vecs[5]  = '{1'b0, 32'h0,  64'h0,  1'b0, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,  0};
    vecs[6]  = '{1'b1, 32'h5,  64'h55, 1'b0, 1'b0, 32'h5,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,  0};
    vecs[7]  = '{1'b0, 32'h0,  64'h0,  1'b1, 1'b1, 32'h5,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,  1};
    vecs[8]  = '{1'b0, 32'h0,  64'h0,  1'b1, 1'b1, 32'h6,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 64'h1,  1};
    vecs[9]  = '{1'b0, 32'h0,  64'h0,  1'b0, 1'b0, 32'h5,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0,  1};
    vecs[10] = '{1'b0, 32'h0,  64'h0,  1'b1, 1'b0, 32'h5,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,  1};
    vecs[11] = '{1'b0, 32'h0,  64'h0,  1'b0, 1'b0, 32'h5,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 64'h55, 0};
    vecs[12] = '{1'b1, 32'h1,  64'h11, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 64'h0,  0};
    vecs[13] = '{1'b1, 32'h2,  64'h22, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 64'h0,  1};
    vecs[14] = '{1'b1, 32'h3,  64'h33, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 64'h0,  2};
    vecs[15] = '{1'b0, 32'h0,  64'h0,  1'b1, 1'b0, 32'h2,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,  3};
    vecs[16] = '{1'b0, 32'h0,  64'h0,  1'b1, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 64'h22, 2};
    vecs[17] = '{1'b0, 32'h0,  64'h0,  1'b1, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 64'h11, 1};
    vecs[18] = '{1'b0, 32'h0,  64'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 64'h33, 0};
    vecs[19] = '{1'b0, 32'h0,  64'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 64'h0,  0};

    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_wb_valid", bus.wb_valid_o, 1'b0);
    chk("reset_wb_data", 64'(bus.wb_data_o == '0), 64'd1);
    chk("reset_occupancy", 64'(bus.occupancy_o), 64'd0);
    chk("reset_net_ready", bus.net_ready_o, 1'b1);
    tick();

    // Directed table: ordering, AVAIL, mask and mid-buffer removal
    for (int k = 0; k < 20; k++) begin
      drive(vecs[k].nv, vecs[k].ntag, vecs[k].ndata, vecs[k].rv, vecs[k].av,
            vecs[k].rtag, vecs[k].tmask, vecs[k].wr);
      @(negedge clk);
      chk($sformatf("vec%0d_net_ready", k), bus.net_ready_o, vecs[k].e_nr);
      chk($sformatf("vec%0d_req_ready", k), bus.req_ready_o, vecs[k].e_rr);
      chk($sformatf("vec%0d_wb_valid", k), bus.wb_valid_o, vecs[k].e_wbv);
      chk($sformatf("vec%0d_occupancy", k), 64'(bus.occupancy_o), 64'(vecs[k].e_occ));
      if (vecs[k].e_wbv) chk($sformatf("vec%0d_wb_value", k), bus.wb_data_o.value, vecs[k].e_val);
      tick();
    end

    // Stall and no bypass
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'h7, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    chk("stall_req_ready_empty", bus.req_ready_o, 1'b0);
    tick();
    drive(1'b1, 32'h7, 64'h77, 1'b1, 1'b0, 32'h7, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    chk("stall_no_bypass", bus.req_ready_o, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'h7, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    chk("stall_req_ready_T1", bus.req_ready_o, 1'b1);
    chk("stall_wb_valid_T1", bus.wb_valid_o, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("stall_wb_valid_T2", bus.wb_valid_o, 1'b1);
    chk("stall_wb_value_T2", bus.wb_data_o.value, 64'h77);
    chk("stall_occupancy_T2", 64'(bus.occupancy_o), 64'd0);
    tick();

    // Full buffer and backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h20 + 32'(i), 64'h200 + 64'(i), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      chk($sformatf("fill%0d_net_ready", i), bus.net_ready_o, 1'b1);
      tick();
    end
    drive(1'b1, 32'h24, 64'h204, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("full_net_ready", bus.net_ready_o, 1'b0);
    chk("full_occupancy", 64'(bus.occupancy_o), 64'd4);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    chk("bp_avail_accept", bus.req_ready_o, 1'b1);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'h21, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    chk("bp_wb_valid", bus.wb_valid_o, 1'b1);
    chk("bp_wb_value", bus.wb_data_o.value, 64'h1);
    chk("bp_req_blocked", bus.req_ready_o, 1'b0);
    held = bus.wb_data_o;
    tick();
    @(negedge clk);
    chk("bp_hold_valid", bus.wb_valid_o, 1'b1);
    chk("bp_hold_data", 64'(bus.wb_data_o == held), 64'd1);
    chk("bp_req_still_blocked", bus.req_ready_o, 1'b0);
    chk("bp_occupancy", 64'(bus.occupancy_o), 64'd4);
    tick();
    // Full + removal: net side stays closed this cycle
    drive(1'b1, 32'h26, 64'h206, 1'b1, 1'b0, 32'h21, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    chk("fullrm_req_ready", bus.req_ready_o, 1'b1);
    chk("fullrm_net_ready", bus.net_ready_o, 1'b0);
    tick();
    // Removal + insert at count 3
    drive(1'b1, 32'h25, 64'h205, 1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    chk("swap_wb_value", bus.wb_data_o.value, 64'h201);
    chk("swap_occ_before", 64'(bus.occupancy_o), 64'd3);
    chk("swap_net_ready", bus.net_ready_o, 1'b1);
    chk("swap_req_ready", bus.req_ready_o, 1'b1);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("swap_occ_after", 64'(bus.occupancy_o), 64'd3);
    chk("swap_value_200", bus.wb_data_o.value, 64'h200);
    tick();
    @(negedge clk);
    chk("drain_value_202", bus.wb_data_o.value, 64'h202);
    tick();
    @(negedge clk);
    chk("drain_value_203", bus.wb_data_o.value, 64'h203);
    tick();
    idle();
    @(negedge clk);
    chk("drain_value_205", bus.wb_data_o.value, 64'h205);
    chk("drain_occupancy", 64'(bus.occupancy_o), 64'd0);
    tick();
    tick();

    // Reset mid-operation
    drive(1'b1, 32'h30, 64'h300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1'b1, 32'h31, 64'h301, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("prereset_wb_valid", bus.wb_valid_o, 1'b1);
    chk("prereset_occupancy", 64'(bus.occupancy_o), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_wb_valid", bus.wb_valid_o, 1'b0);
    chk("midreset_wb_data", 64'(bus.wb_data_o == '0), 64'd1);
    chk("midreset_occupancy", 64'(bus.occupancy_o), 64'd0);
    chk("midreset_net_ready", bus.net_ready_o, 1'b1);
    tick();

    // Randomized traffic against the queue model (DUT is empty and idle here)
    mq.delete();
    m_wbv = 1'b0;
    m_val = '0;
    m_pt  = '0;
    for (int c = 0; c < 3000; c++) rand_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
